// File: rtl/vga_timing_if.sv
// Pixel-side signal bundle for vga_timing: enable in, counters, strobes and sync pins out.
interface vga_timing_if;
    logic       en;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       visible;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
    logic       hsync;
    logic       vsync;
    logic       blank;

    // Timing generator side
    modport master (
        input  en,
        output pixel_x, pixel_y, visible, line_start, frame_start, frame_count,
        output hsync, vsync, blank
    );

    // Consumer side (video pipeline / bench)
    modport slave (
        output en,
        input  pixel_x, pixel_y, visible, line_start, frame_start, frame_count,
        input  hsync, vsync, blank
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, strobes, frame counter and
// sync/blank pins with a configurable pixel-pipeline delay.
module vga_timing #(
    parameter int unsigned VGA_WIDTH       = 640,
    parameter int unsigned VGA_HEIGHT      = 480,
    parameter int unsigned H_FRONT_PORCH   = 16,
    parameter int unsigned H_SYNC_PULSE    = 96,
    parameter int unsigned H_BACK_PORCH    = 48,
    parameter int unsigned V_FRONT_PORCH   = 10,
    parameter int unsigned V_SYNC_PULSE    = 2,
    parameter int unsigned V_BACK_PORCH    = 33,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned SYNC_DELAY      = 1
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master bus
);

    localparam int unsigned H_TOTAL = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int unsigned V_TOTAL = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(VGA_WIDTH);
    localparam logic [9:0] V_ACT    = 10'(VGA_HEIGHT);
    localparam logic [9:0] HS_FIRST = 10'(VGA_WIDTH + H_FRONT_PORCH);
    localparam logic [9:0] HS_LAST  = 10'(VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    localparam logic [9:0] VS_FIRST = 10'(VGA_HEIGHT + V_FRONT_PORCH);
    localparam logic [9:0] VS_LAST  = 10'(VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE - 1);

    // Idle pin levels, packed as {blank, vsync, hsync}
    localparam logic [2:0] PINS_IDLE = {1'b1, SYNC_ACTIVE_LOW, SYNC_ACTIVE_LOW};

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [7:0] r_fc;
    logic       w_x_wrap;
    logic       w_y_wrap;
    logic       w_visible;
    logic       w_hs_act;
    logic       w_vs_act;
    logic [2:0] w_pins_raw;
    logic [2:0] w_pins_out;

    assign w_x_wrap = (r_x == H_MAX);
    assign w_y_wrap = (r_y == V_MAX);

    // Raster counters and completed-frame counter; wrap before exceeding totals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x  <= '0;
            r_y  <= '0;
            r_fc <= '0;
        end else if (bus.en) begin
            r_x <= w_x_wrap ? 10'd0 : r_x + 10'd1;
            if (w_x_wrap) begin
                r_y <= w_y_wrap ? 10'd0 : r_y + 10'd1;
                if (w_y_wrap) begin
                    r_fc <= r_fc + 8'd1;
                end
            end
        end
    end

    assign w_visible  = (r_x < H_ACT) && (r_y < V_ACT);
    assign w_hs_act   = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
    assign w_vs_act   = (r_y >= VS_FIRST) && (r_y <= VS_LAST);
    assign w_pins_raw = {~w_visible, w_vs_act ^ SYNC_ACTIVE_LOW, w_hs_act ^ SYNC_ACTIVE_LOW};

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign w_pins_out = w_pins_raw;
        end else begin : g_delay
            logic [2:0] r_pipe [SYNC_DELAY];

            // Pin delay line; advances only on enabled pixels so it tracks the counters
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(SYNC_DELAY); i++) begin
                        r_pipe[i] <= PINS_IDLE;
                    end
                end else if (bus.en) begin
                    r_pipe[0] <= w_pins_raw;
                    for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_pins_out = r_pipe[SYNC_DELAY-1];
        end
    endgenerate

    assign bus.pixel_x     = r_x;
    assign bus.pixel_y     = r_y;
    assign bus.frame_count = r_fc;
    assign bus.visible     = w_visible;
    // Gated by en so a stalled first pixel strobes only once
    assign bus.line_start  = bus.en && (r_x == 10'd0);
    assign bus.frame_start = bus.en && (r_x == 10'd0) && (r_y == 10'd0);
    assign bus.hsync       = w_pins_out[0];
    assign bus.vsync       = w_pins_out[1];
    assign bus.blank       = w_pins_out[2];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: small-raster DUTs (delayed active-low, undelayed active-high)
// checked via a scoreboard queue, plus a default-size DUT checked per line.
module tb_vga_timing;

    // Small raster: H_TOTAL=15 (hsync x 10..12), V_TOTAL=8 (vsync y 5..6), 120 clocks/frame
    localparam int SEL_MODEL = 0;
    localparam int SEL_AX    = 1;
    localparam int SEL_AY    = 2;
    localparam int SEL_AFC   = 3;
    localparam int SEL_ALS   = 4;
    localparam int SEL_AFS   = 5;
    localparam int SEL_AHS   = 6;
    localparam int SEL_AVS   = 7;
    localparam int SEL_ABL   = 8;
    localparam int SEL_BHS   = 9;
    localparam int SEL_BBL   = 10;
    localparam int SEL_AVIS  = 11;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] exp;
        string       name;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    vga_timing_if if_a ();
    vga_timing_if if_b ();
    vga_timing_if if_c ();

    assign if_a.en = en;
    assign if_b.en = en;
    assign if_c.en = en;

    vga_timing #(
        .VGA_WIDTH(8), .VGA_HEIGHT(4),
        .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
        .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .SYNC_ACTIVE_LOW(1'b1), .SYNC_DELAY(1)
    ) u_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );

    vga_timing #(
        .VGA_WIDTH(8), .VGA_HEIGHT(4),
        .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
        .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .SYNC_ACTIVE_LOW(1'b0), .SYNC_DELAY(0)
    ) u_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    vga_timing #(
        .SYNC_DELAY(2)
    ) u_c (
        .clk(clk), .rst(rst), .bus(if_c)
    );

    item_t      sb_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Reference model state
    logic [9:0] mx = '0;
    logic [9:0] my = '0;
    logic [7:0] mfc = '0;
    logic       mp_hs = 1'b1;
    logic       mp_vs = 1'b1;
    logic       mp_bl = 1'b1;

    // Default-raster line monitor state
    bit         c_started = 1'b0;
    int         c_len = 0;
    int         c_low = 0;

    function automatic logic [36:0] model_vec();
        logic vis;
        vis = (mx < 10'd8) && (my < 10'd4);
        return {mx, my, mfc, vis, en && (mx == 10'd0), en && (mx == 10'd0) && (my == 10'd0),
                mp_hs, mp_vs, mp_bl,
                (mx >= 10'd10) && (mx <= 10'd12), (my >= 10'd5) && (my <= 10'd6), !vis};
    endfunction

    function automatic logic [63:0] get_act(input int sel);
        case (sel)
            SEL_MODEL: return 64'({if_a.pixel_x, if_a.pixel_y, if_a.frame_count, if_a.visible,
                                   if_a.line_start, if_a.frame_start,
                                   if_a.hsync, if_a.vsync, if_a.blank,
                                   if_b.hsync, if_b.vsync, if_b.blank});
            SEL_AX:    return 64'(if_a.pixel_x);
            SEL_AY:    return 64'(if_a.pixel_y);
            SEL_AFC:   return 64'(if_a.frame_count);
            SEL_ALS:   return 64'(if_a.line_start);
            SEL_AFS:   return 64'(if_a.frame_start);
            SEL_AHS:   return 64'(if_a.hsync);
            SEL_AVS:   return 64'(if_a.vsync);
            SEL_ABL:   return 64'(if_a.blank);
            SEL_BHS:   return 64'(if_b.hsync);
            SEL_BBL:   return 64'(if_b.blank);
            SEL_AVIS:  return 64'(if_a.visible);
            default:   return '1;
        endcase
    endfunction

    task automatic chk(input int sel, input logic [63:0] exp, input string name);
        item_t it;
        it.cyc  = cyc;
        it.sel  = sel;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    // Advance one clock: apply the edge to the model, set new inputs, queue expectations
    task automatic step(input logic n_en, input logic n_rst);
        logic vis;
        @(posedge clk);
        #1;
        if (!rst && en) begin
            vis   = (mx < 10'd8) && (my < 10'd4);
            mp_hs = !((mx >= 10'd10) && (mx <= 10'd12));
            mp_vs = !((my >= 10'd5) && (my <= 10'd6));
            mp_bl = !vis;
            if (mx == 10'd14) begin
                mx = '0;
                if (my == 10'd7) begin
                    my  = '0;
                    mfc = mfc + 8'd1;
                end else begin
                    my = my + 10'd1;
                end
            end else begin
                mx = mx + 10'd1;
            end
        end
        en  = n_en;
        rst = n_rst;
        if (n_rst) begin
            mx    = '0;
            my    = '0;
            mfc   = '0;
            mp_hs = 1'b1;
            mp_vs = 1'b1;
            mp_bl = 1'b1;
        end
        cyc = cyc + 1;
        chk(SEL_MODEL, 64'(model_vec()), "model");
    endtask

    // Hand-computed values for cycle n of a continuous en=1 run starting at (0,0)
    task automatic hand(input int n);
        case (n)
            0: begin
                chk(SEL_AFS, 1, "first_fs"); chk(SEL_ALS, 1, "first_ls");
                chk(SEL_AX, 0, "first_x"); chk(SEL_AY, 0, "first_y");
                chk(SEL_AHS, 1, "first_hs"); chk(SEL_AVS, 1, "first_vs");
                chk(SEL_ABL, 1, "first_blank");
            end
            7:     chk(SEL_BBL, 0, "b_blank_x7");
            8:     begin chk(SEL_BBL, 1, "b_blank_x8"); chk(SEL_AVIS, 0, "vis_x8"); end
            9:     begin chk(SEL_BHS, 0, "b_hs_x9"); chk(SEL_AHS, 1, "a_hs_x9"); end
            10:    begin chk(SEL_BHS, 1, "b_hs_x10"); chk(SEL_AHS, 1, "a_hs_x10"); end
            11:    chk(SEL_AHS, 0, "a_hs_x11");
            12:    chk(SEL_BHS, 1, "b_hs_x12");
            13:    begin chk(SEL_BHS, 0, "b_hs_x13"); chk(SEL_AHS, 0, "a_hs_x13"); end
            14:    chk(SEL_AHS, 1, "a_hs_x14");
            15: begin
                chk(SEL_ALS, 1, "ls_y1"); chk(SEL_AFS, 0, "fs_y1");
                chk(SEL_AX, 0, "x_y1"); chk(SEL_AY, 1, "y_y1");
            end
            60:    begin chk(SEL_BBL, 1, "b_blank_y4"); chk(SEL_AVIS, 0, "vis_y4"); end
            75:    chk(SEL_AVS, 1, "a_vs_y5x0");
            76:    chk(SEL_AVS, 0, "a_vs_y5x1");
            105:   chk(SEL_AVS, 0, "a_vs_y7x0");
            106:   chk(SEL_AVS, 1, "a_vs_y7x1");
            120:   begin chk(SEL_AFS, 1, "fs_frame1"); chk(SEL_AFC, 1, "fc_frame1"); end
            155: begin
                chk(SEL_AX, 5, "x_mid"); chk(SEL_AY, 2, "y_mid");
                chk(SEL_AFC, 1, "fc_mid"); chk(SEL_ABL, 0, "blank_mid");
            end
            30599: chk(SEL_AFC, 254, "fc_254");
            30600: begin chk(SEL_AFC, 255, "fc_255"); chk(SEL_AFS, 1, "fs_255"); end
            30719: begin
                chk(SEL_AX, 14, "x_last"); chk(SEL_AY, 7, "y_last"); chk(SEL_AFC, 255, "fc_last");
            end
            30720: begin
                chk(SEL_AFC, 0, "fc_wrap"); chk(SEL_AFS, 1, "fs_wrap");
                chk(SEL_AX, 0, "x_wrap"); chk(SEL_AY, 0, "y_wrap");
            end
            default: ;
        endcase
    endtask

    // Monitor: scoreboard compare for small DUTs and line-length/hsync checks for u_c
    always @(negedge clk) begin
        item_t       it;
        logic [63:0] act;
        while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            it     = sb_q.pop_front();
            act    = get_act(it.sel);
            checks = checks + 1;
            if (act !== it.exp) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", it.name, cyc, act, it.exp);
            end
        end
        if (rst) begin
            c_started = 1'b0;
        end else if (en) begin
            if (if_c.line_start) begin
                if (c_started) begin
                    checks = checks + 2;
                    if (c_len != 800) begin
                        errors = errors + 1;
                        $display("FAIL c_line_len cyc=%0d got=%0d expected=800", cyc, c_len);
                    end
                    if (c_low != 96) begin
                        errors = errors + 1;
                        $display("FAIL c_hsync_low cyc=%0d got=%0d expected=96", cyc, c_low);
                    end
                end
                c_started = 1'b1;
                c_len     = 0;
                c_low     = 0;
            end
            c_len = c_len + 1;
            if (!if_c.hsync) c_low = c_low + 1;
        end
    end

    initial begin
        en  = 1'b0;
        rst = 1'b1;

        // In reset with en=1: counters held at zero, pins idle, strobes combinational
        step(1'b1, 1'b1);
        chk(SEL_AX, 0, "rst_x"); chk(SEL_AY, 0, "rst_y"); chk(SEL_AFC, 0, "rst_fc");
        chk(SEL_AHS, 1, "rst_hs"); chk(SEL_AVS, 1, "rst_vs"); chk(SEL_ABL, 1, "rst_blank");
        chk(SEL_ALS, 1, "rst_ls"); chk(SEL_AFS, 1, "rst_fs");
        chk(SEL_BHS, 0, "rst_b_hs"); chk(SEL_BBL, 0, "rst_b_blank");

        // en toggling 1,0,1,0,1
        step(1'b1, 1'b0); chk(SEL_AX, 0, "tog0_x"); chk(SEL_ALS, 1, "tog0_ls");
        chk(SEL_AFS, 1, "tog0_fs");
        step(1'b0, 1'b0); chk(SEL_AX, 1, "tog1_x"); chk(SEL_ALS, 0, "tog1_ls");
        step(1'b1, 1'b0); chk(SEL_AX, 1, "tog2_x"); chk(SEL_ALS, 0, "tog2_ls");
        step(1'b0, 1'b0); chk(SEL_AX, 2, "tog3_x");
        step(1'b1, 1'b0); chk(SEL_AX, 2, "tog4_x"); chk(SEL_ALS, 0, "tog4_ls");

        // Clean run to (5,2) of the second frame
        step(1'b0, 1'b1); chk(SEL_ALS, 0, "rst_en0_ls");
        for (int n = 0; n <= 155; n++) begin
            step(1'b1, 1'b0);
            hand(n);
        end

        // Mid-frame reset clears asynchronously, then restart after release
        step(1'b1, 1'b1);
        chk(SEL_AX, 0, "mid_rst_x"); chk(SEL_AY, 0, "mid_rst_y"); chk(SEL_AFC, 0, "mid_rst_fc");
        chk(SEL_AHS, 1, "mid_rst_hs"); chk(SEL_AVS, 1, "mid_rst_vs");
        chk(SEL_ABL, 1, "mid_rst_blank");
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0); chk(SEL_AX, 0, "rel_x"); chk(SEL_ALS, 0, "rel_ls");
        chk(SEL_AFS, 0, "rel_fs");

        // 256 frames continuous: frame_count wraps 255 -> 0
        for (int n = 0; n <= 30721; n++) begin
            step(1'b1, 1'b0);
            hand(n);
        end

        // Irregular enable pattern, model-checked
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
